// File: rtl/seg_scan.sv
// seg_scan: 4-digit multiplexed 7-seg driver; outputs registered (1-cycle latency), no backpressure.
// Optional leading-zero blanking via SEG_LZ_BLANK_EN; digits are latched once per frame.
module seg_scan #(
  parameter int SCAN_DIV = 100000,
  parameter int GAP_CYC  = 1000
) (
  input  logic        clk,
  input  logic        btnC,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  blank,
  output logic [3:0]  segEn,
  output logic [6:0]  seg
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] div_cnt;
  logic [1:0]    dig_sel;
  logic [15:0]   shadow;
  logic          slot_end;
  logic          frame_end;
  logic [3:0]    nib;
  logic [3:0]    lz_blank;
  logic          dark;
  logic [3:0]    en_d;
  logic [6:0]    seg_d;

  assign slot_end  = (div_cnt == CW'(SCAN_DIV - 1));
  assign frame_end = slot_end && (dig_sel == 2'd3);

  always_ff @(posedge clk or posedge btnC) begin
    if (btnC) begin
      div_cnt <= '0;
      dig_sel <= 2'd0;
      shadow  <= 16'h0000;
    end else begin
      div_cnt <= slot_end ? '0 : div_cnt + 1'b1;
      if (slot_end)
        dig_sel <= dig_sel + 2'd1;
      // Only whole frames are shown, so a mid-frame bcd_in change never tears the display.
      if (frame_end)
        shadow <= bcd_in;
    end
  end

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h3F;
    endcase
  endfunction

  always_comb begin
    case (dig_sel)
      2'd0:    nib = shadow[3:0];
      2'd1:    nib = shadow[7:4];
      2'd2:    nib = shadow[11:8];
      default: nib = shadow[15:12];
    endcase
  end

`ifdef SEG_LZ_BLANK_EN
  always_comb begin
    lz_blank    = 4'b0000;
    lz_blank[3] = (shadow[15:12] == 4'd0);
    lz_blank[2] = lz_blank[3] && (shadow[11:8] == 4'd0);
    lz_blank[1] = lz_blank[2] && (shadow[7:4] == 4'd0);
  end
`else
  assign lz_blank = 4'b0000;
`endif

  // Gap at the start of every slot lets the previous anode fully turn off before new cathodes.
  always_comb begin
    dark  = (div_cnt < CW'(GAP_CYC)) || blank[dig_sel] || lz_blank[dig_sel];
    en_d  = dark ? 4'b1111 : ~(4'b0001 << dig_sel);
    seg_d = dark ? 7'h7F : decode(nib);
  end

  always_ff @(posedge clk or posedge btnC) begin
    if (btnC) begin
      segEn <= 4'b1111;
      seg   <= 7'h7F;
    end else begin
      segEn <= en_d;
      seg   <= seg_d;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with SCAN_DIV=10, GAP_CYC=2; build with +define+SEG_LZ_BLANK_EN for the LZ variant.
module tb_seg_scan;

  localparam int SD  = 10;
  localparam int GAP = 2;
`ifdef SEG_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        btnC;
  logic [15:0] bcd_in;
  logic [3:0]  blank;
  logic [3:0]  segEn;
  logic [6:0]  seg;

  int total = 0;
  int bad   = 0;

  seg_scan #(.SCAN_DIV(SD), .GAP_CYC(GAP)) dut (
    .clk    (clk),
    .btnC   (btnC),
    .bcd_in (bcd_in),
    .blank  (blank),
    .segEn  (segEn),
    .seg    (seg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walks n cycles of one slot: GAP dark cycles, then the digit (or dark if not lit).
  task automatic check_slot(input string tag, input int d, input logic [6:0] exp_seg,
                            input bit lit, input int n);
    logic [3:0] on_en;
    on_en = ~(4'b0001 << d);
    for (int i = 0; i < n; i++) begin
      step();
      chk({tag, ".onehot"}, 16'(($countones(~segEn) <= 1) ? 1 : 0), 16'd1);
      if (i < GAP || !lit) begin
        chk({tag, ".en_off"}, 16'(segEn), 16'h000F);
        chk({tag, ".seg_off"}, 16'(seg), 16'h007F);
      end else begin
        chk({tag, ".en"}, 16'(segEn), 16'(on_en));
        chk({tag, ".seg"}, 16'(seg), 16'(exp_seg));
      end
    end
  endtask

  initial begin
    btnC   = 1'b1;
    bcd_in = 16'h0059;
    blank  = 4'b0000;
    #2;
    chk("rst_async_en", 16'(segEn), 16'h000F);
    chk("rst_async_seg", 16'(seg), 16'h007F);
    step(); step(); step();
    chk("rst_hold_en", 16'(segEn), 16'h000F);
    chk("rst_hold_seg", 16'(seg), 16'h007F);
    btnC = 1'b0;

    // Frame 1: shadow still 0000.
    check_slot("f1d0", 0, 7'h40, 1'b1, SD);
    check_slot("f1d1", 1, 7'h40, !LZ, SD);
    check_slot("f1d2", 2, 7'h40, !LZ, SD);
    check_slot("f1d3", 3, 7'h40, !LZ, SD);

    // Frame 2: 0059 latched.
    check_slot("f2d0", 0, 7'h10, 1'b1, SD);
    check_slot("f2d1", 1, 7'h12, 1'b1, SD);
    check_slot("f2d2", 2, 7'h40, !LZ, SD);
    check_slot("f2d3", 3, 7'h40, !LZ, SD);

    // Frame 3: change bcd_in during digit1 slot; frame must not tear.
    check_slot("f3d0", 0, 7'h10, 1'b1, SD);
    bcd_in = 16'h1234;
    check_slot("f3d1", 1, 7'h12, 1'b1, SD);
    check_slot("f3d2", 2, 7'h40, !LZ, SD);
    check_slot("f3d3", 3, 7'h40, !LZ, SD);

    // Frame 4: 1234.
    bcd_in = 16'h00A0;
    check_slot("f4d0", 0, 7'h19, 1'b1, SD);
    check_slot("f4d1", 1, 7'h30, 1'b1, SD);
    check_slot("f4d2", 2, 7'h24, 1'b1, SD);
    check_slot("f4d3", 3, 7'h79, 1'b1, SD);

    // Frame 5: 00A0, out-of-range nibble shows dash.
    check_slot("f5d0", 0, 7'h40, 1'b1, SD);
    check_slot("f5d1", 1, 7'h3F, 1'b1, SD);
    check_slot("f5d2", 2, 7'h40, !LZ, SD);
    check_slot("f5d3", 3, 7'h40, !LZ, SD);

    // Frame 6: force-blank digit1 for its whole slot.
    bcd_in = 16'h1234;
    check_slot("f6d0", 0, 7'h40, 1'b1, SD);
    blank = 4'b0010;
    check_slot("f6d1blk", 1, 7'h3F, 1'b0, SD);
    blank = 4'b0000;
    check_slot("f6d2", 2, 7'h40, !LZ, SD);
    check_slot("f6d3", 3, 7'h40, !LZ, SD);

    // Frame 7: reset in the middle of a lit digit2 slot.
    check_slot("f7d0", 0, 7'h19, 1'b1, SD);
    check_slot("f7d1", 1, 7'h30, 1'b1, SD);
    check_slot("f7d2", 2, 7'h24, 1'b1, 5);
    btnC = 1'b1;
    #1;
    chk("midrst_en", 16'(segEn), 16'h000F);
    chk("midrst_seg", 16'(seg), 16'h007F);
    step(); step();
    chk("midrst_hold_en", 16'(segEn), 16'h000F);
    chk("midrst_hold_seg", 16'(seg), 16'h007F);
    btnC = 1'b0;

    // After reset: shadow 0000 for one frame, then 1234.
    check_slot("r1d0", 0, 7'h40, 1'b1, SD);
    check_slot("r1d1", 1, 7'h40, !LZ, SD);
    check_slot("r1d2", 2, 7'h40, !LZ, SD);
    check_slot("r1d3", 3, 7'h40, !LZ, SD);
    check_slot("r2d0", 0, 7'h19, 1'b1, SD);
    check_slot("r2d1", 1, 7'h30, 1'b1, SD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
